nv_nvdla_dmaif_rdreq_gen: RTL and testbench
===========================================

Name: nv_nvdla_dmaif_rdreq_gen

Overview:
Read-request generator that sits directly upstream of the DMAIF read-request router and drives its dmaif_rd_req_pd/vld/rdy input. It takes one linear read command (base address + length in atoms) from a client engine and splits it into memory requests. No request exceeds MAX_REQ_ATOMS, and no request crosses a 4 KB boundary. Issue is gated by a credit counter that mirrors the client's response latency-FIFO space, so read data can never overflow it.

Parameters:
MEM_AW, 64, memory address width; the request payload is MEM_AW+15 bits.
ATOM_LOG2, 5, log2 of atom size in bytes (32 B atoms).
MAX_REQ_ATOMS, 8, maximum atoms per emitted request (1..128).
CREDIT_DEPTH, 64, latency-FIFO depth in atoms; this is the credit reset value.

Ports:
nvdla_core_clk  in  1  core clock
nvdla_core_rstn  in  1  synchronous active-low reset, sampled on rising nvdla_core_clk
cmd_vld  in  1  command valid
cmd_rdy  out  1  command ready
cmd_addr  in  MEM_AW  start byte address; atom aligned
cmd_size  in  15  command length in atoms minus one
dmaif_rd_req_pd  out  MEM_AW+15  [MEM_AW-1:0]=byte addr; [MEM_AW+14:MEM_AW]=request atoms minus one
dmaif_rd_req_vld  out  1  request valid
dmaif_rd_req_rdy  in  1  request ready (from router)
rsp_atom_pop  in  1  client popped one atom from its latency FIFO; returns 1 credit
busy  out  1  command in progress
credit_cnt  out  clog2(CREDIT_DEPTH)+1  free credits

Behaviour:
- Reset (synchronous, nvdla_core_rstn=0 at a clock edge):
  - cmd_rdy=0 during reset; 1 on the first cycle after reset.
  - dmaif_rd_req_vld=0, dmaif_rd_req_pd=0, busy=0, credit_cnt=CREDIT_DEPTH, FSM=IDLE.
  - Reset mid-operation drops the current command and any pending request immediately; the held request is not completed.
- FSM states: IDLE, CALC, ISSUE.
  - IDLE: cmd_rdy=1. On cmd_vld&cmd_rdy:
    - latch cur_addr = cmd_addr with the low ATOM_LOG2 bits forced to 0;
    - latch remain = cmd_size+1 (16-bit);
    - busy=1; go to CALC.
  - CALC (1 cycle):
    - chunk = min(MAX_REQ_ATOMS, remain, 2^(12-ATOM_LOG2) - cur_addr[11:ATOM_LOG2]);
    - register pd = {chunk-1 (15b), cur_addr}; go to ISSUE.
  - ISSUE: assert vld only when credit_cnt >= chunk.
    - While the credit check fails, vld=0; vld never drops once asserted.
    - While vld & !rdy, pd and vld are held stable.
    - On vld & rdy: cur_addr += chunk<<ATOM_LOG2; remain -= chunk; credit_cnt -= chunk.
    - Then, if remain==0: go to IDLE, busy=0, cmd_rdy=1 the next cycle. Otherwise go to CALC.
- Latency and throughput:
  - First request vld is 2 cycles after command acceptance, given sufficient credit.
  - Sustained rate is one request per 2 cycles.
- Credits:
  - credit_cnt' = credit_cnt - (handshake ? chunk : 0) + rsp_atom_pop.
  - Simultaneous handshake and pop are both applied in the same cycle.
  - rsp_atom_pop while credit_cnt==CREDIT_DEPTH is a protocol violation: the count saturates at CREDIT_DEPTH, and a simulation assertion fires.
  - Credits persist across commands; only reset restores them.
- Arithmetic:
  - Address increment wraps modulo 2^MEM_AW without error.
  - The 4 KB split uses the post-increment address; the address after a split is 4 KB aligned.
- cmd_size=0 produces exactly one 1-atom request.
- The maximum command length of 32768 atoms is supported (16-bit remain).
- dmaif_rd_req_pd is registered directly from flops; no combinational path from rdy to vld or pd.

Optional Feature:
Macro NVDLA_DMAIF_RDREQ_PERF_EN.
- Defined:
  - adds output perf_stall_cnt [31:0];
  - increments each cycle in ISSUE where vld&!rdy, or where vld is withheld for lack of credit;
  - saturates at 0xFFFFFFFF; clears on reset and on command acceptance.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Split at 4 KB boundary: cmd_addr=0x0FC0, cmd_size=9 (10 atoms), rdy=1, ample credit -> requests {addr 0x0FC0, size 1} then {addr 0x1000, size 7}; busy deasserts after the second handshake.
- MAX_REQ_ATOMS split: cmd_addr=0x2000, cmd_size=19 -> three requests of 8, 8, 4 atoms (size fields 7, 7, 3) at 0x2000, 0x2100, 0x2200; credit_cnt 64->44.
- Credit throttle: CREDIT_DEPTH=64, cmd_size=127 with no pops -> exactly 8 requests issue, then vld stays 0 with credit_cnt=0. Pulsing rsp_atom_pop 8 times -> next request issues one cycle after credit_cnt reaches 8.
- Backpressure hold: rdy=0 for 5 cycles with vld=1 -> pd and vld stable all 5 cycles; a single handshake follows rdy=1. With PERF_EN, perf_stall_cnt=5.
- Simultaneous return: handshake of 8 atoms in the same cycle as rsp_atom_pop=1 with credit_cnt=20 -> credit_cnt=13 the next cycle.
- Reset mid-op: assert nvdla_core_rstn=0 while vld=1, rdy=0 -> at the next edge vld=0, busy=0, credit_cnt=64; cmd_rdy=1 on the first cycle after release.

Source files
------------

// File: rtl/nv_nvdla_dmaif_rdreq_gen.sv
// -----------------------------------------------------------------------------
// nv_nvdla_dmaif_rdreq_gen
//
// Splits one linear read command into DMAIF read requests. No request is
// longer than MAX_REQ_ATOMS, and no request crosses a 4 KB boundary. Each
// request is issued only when enough credits are free. The credits track free
// space in the client's response latency FIFO, so that FIFO cannot overflow.
//
// Ports:
//   nvdla_core_clk     core clock
//   nvdla_core_rstn    synchronous active-low reset
//   cmd_vld/cmd_rdy    command handshake
//   cmd_addr           start byte address (low ATOM_LOG2 bits are ignored)
//   cmd_size           command length in atoms minus one
//   dmaif_rd_req_pd    {atoms-1 [MEM_AW+14:MEM_AW], byte addr [MEM_AW-1:0]}
//   dmaif_rd_req_vld   request valid (registered)
//   dmaif_rd_req_rdy   request ready from the router
//   rsp_atom_pop       client popped one atom; returns one credit
//   busy               a command is in progress
//   credit_cnt         free credits
//   perf_stall_cnt     ISSUE stall cycles; present only when the optional
//                      macro NVDLA_DMAIF_RDREQ_PERF_EN is defined
// -----------------------------------------------------------------------------
module nv_nvdla_dmaif_rdreq_gen #(
    parameter int unsigned MEM_AW        = 64,
    parameter int unsigned ATOM_LOG2     = 5,
    parameter int unsigned MAX_REQ_ATOMS = 8,
    parameter int unsigned CREDIT_DEPTH  = 64,
    localparam int unsigned CW           = $clog2(CREDIT_DEPTH) + 1
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rstn,
    input  logic                cmd_vld,
    output logic                cmd_rdy,
    input  logic [MEM_AW-1:0]   cmd_addr,
    input  logic [14:0]         cmd_size,
    output logic [MEM_AW+14:0]  dmaif_rd_req_pd,
    output logic                dmaif_rd_req_vld,
    input  logic                dmaif_rd_req_rdy,
    input  logic                rsp_atom_pop,
    output logic                busy,
    output logic [CW-1:0]       credit_cnt
`ifdef NVDLA_DMAIF_RDREQ_PERF_EN
    ,
    output logic [31:0]         perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_e;

    state_e               state_q, state_d;
    logic [MEM_AW-1:0]    cur_addr_q, cur_addr_d;
    logic [15:0]          remain_q, remain_d;
    logic [15:0]          chunk_q, chunk_d;
    logic [MEM_AW+14:0]   pd_q, pd_d;
    logic                 vld_q, vld_d;
    logic                 busy_q, busy_d;
    logic [CW-1:0]        credit_q, credit_d;

    logic                 accept;
    logic                 hs;
    logic [15:0]          to_4k;
    logic [15:0]          chunk_calc;
    logic [15:0]          remain_after;
    logic [CW:0]          credit_sum;

    assign cmd_rdy          = nvdla_core_rstn && (state_q == IDLE);
    assign accept           = cmd_vld && cmd_rdy;
    assign hs               = vld_q && dmaif_rd_req_rdy;
    assign dmaif_rd_req_pd  = pd_q;
    assign dmaif_rd_req_vld = vld_q;
    assign busy             = busy_q;
    assign credit_cnt       = credit_q;

    // Atoms left before the next 4 KB boundary, then the three-way minimum.
    always_comb begin
        to_4k      = 16'(1 << (12 - ATOM_LOG2)) - 16'(cur_addr_q[11:ATOM_LOG2]);
        chunk_calc = 16'(MAX_REQ_ATOMS);
        if (remain_q < chunk_calc) chunk_calc = remain_q;
        if (to_4k < chunk_calc)    chunk_calc = to_4k;
    end

    // Apply the handshake debit and the pop refund together. The count stays
    // at CREDIT_DEPTH if an illegal extra pop arrives.
    always_comb begin
        credit_sum = {1'b0, credit_q}
                   - (hs ? (CW+1)'(chunk_q) : '0)
                   + (CW+1)'(rsp_atom_pop);
        if (credit_sum > (CW+1)'(CREDIT_DEPTH))
            credit_d = CW'(CREDIT_DEPTH);
        else
            credit_d = credit_sum[CW-1:0];
    end

    // State register (all sequential state)
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            remain_q   <= '0;
            chunk_q    <= '0;
            pd_q       <= '0;
            vld_q      <= 1'b0;
            busy_q     <= 1'b0;
            credit_q   <= CW'(CREDIT_DEPTH);
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            remain_q   <= remain_d;
            chunk_q    <= chunk_d;
            pd_q       <= pd_d;
            vld_q      <= vld_d;
            busy_q     <= busy_d;
            credit_q   <= credit_d;
        end
    end

    assign remain_after = remain_q - chunk_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    state_d = ISSUE;
            ISSUE:   if (hs) state_d = (remain_after == '0) ? IDLE : CALC;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath logic
    always_comb begin
        cur_addr_d = cur_addr_q;
        remain_d   = remain_q;
        chunk_d    = chunk_q;
        pd_d       = pd_q;
        vld_d      = vld_q;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cur_addr_d = cmd_addr & ~MEM_AW'((1 << ATOM_LOG2) - 1);
                    remain_d   = 16'(cmd_size) + 16'd1;
                    busy_d     = 1'b1;
                end
            end
            CALC: begin
                chunk_d = chunk_calc;
                pd_d    = {15'(chunk_calc - 16'd1), cur_addr_q};
                // Credit cannot fall before ISSUE, so this check is safe.
                vld_d   = (32'(credit_q) >= 32'(chunk_calc));
            end
            ISSUE: begin
                if (!vld_q && (32'(credit_q) >= 32'(chunk_q)))
                    vld_d = 1'b1;
                if (hs) begin
                    vld_d      = 1'b0;
                    cur_addr_d = cur_addr_q + (MEM_AW'(chunk_q) << ATOM_LOG2);
                    remain_d   = remain_after;
                    if (remain_after == '0) busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

`ifdef NVDLA_DMAIF_RDREQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    // In ISSUE, any cycle without a handshake is a stall: either the request
    // is back-pressured or it is held back by missing credit.
    always_comb begin
        perf_d = perf_q;
        if (accept)
            perf_d = '0;
        else if ((state_q == ISSUE) && !hs && (perf_q != '1))
            perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) perf_q <= '0;
        else                  perf_q <= perf_d;
    end

    assign perf_stall_cnt = perf_q;
`endif

`ifndef SYNTHESIS
    credit_overflow_a: assert property (@(posedge nvdla_core_clk)
        disable iff (!nvdla_core_rstn)
        !(rsp_atom_pop && (credit_q == CW'(CREDIT_DEPTH))));
`endif

endmodule

// File: tb/tb_nv_nvdla_dmaif_rdreq_gen.sv
module tb_nv_nvdla_dmaif_rdreq_gen;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned MAXR  = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic [63:0] cmd_addr = '0;
    logic [14:0] cmd_size = '0;
    logic [78:0] pd;
    logic        vld;
    logic        rdy = 1'b0;
    logic        pop = 1'b0;
    logic        busy;
    logic [6:0]  credit;
`ifdef NVDLA_DMAIF_RDREQ_PERF_EN
    logic [31:0] perf;
`endif

    always #5 clk = ~clk;

    nv_nvdla_dmaif_rdreq_gen #(
        .MEM_AW(64), .ATOM_LOG2(5), .MAX_REQ_ATOMS(8), .CREDIT_DEPTH(64)
    ) dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rstn  (rstn),
        .cmd_vld          (cmd_vld),
        .cmd_rdy          (cmd_rdy),
        .cmd_addr         (cmd_addr),
        .cmd_size         (cmd_size),
        .dmaif_rd_req_pd  (pd),
        .dmaif_rd_req_vld (vld),
        .dmaif_rd_req_rdy (rdy),
        .rsp_atom_pop     (pop),
        .busy             (busy),
        .credit_cnt       (credit)
`ifdef NVDLA_DMAIF_RDREQ_PERF_EN
        ,
        .perf_stall_cnt   (perf)
`endif
    );

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [78:0] mk_pd(input int unsigned n, input logic [63:0] a);
        return {15'(n - 1), a};
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct { logic [63:0] addr; int unsigned n; } req_t;
    req_t        expq[$];
    int          credit_m = DEPTH;
    bit          busy_m = 0;
    bit          mdl_on = 0;
    bit          rst_prev = 0;
    bit          prev_hold = 0;
    logic [78:0] prev_pd = '0;
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;
    int unsigned hs_cyc[$];
    logic [78:0] hs_pd[$];

    // Whole command -> list of requests (min of max size, remaining, 4 KB room)
    function automatic void split(input logic [63:0] a0, input int unsigned n0);
        logic [63:0] a = a0 & ~64'h1F;
        int unsigned n = n0;
        int unsigned c, room;
        while (n > 0) begin
            room = 32'd128 - 32'(a[11:5]);
            c = MAXR;
            if (n < c) c = n;
            if (room < c) c = room;
            expq.push_back('{addr: a, n: c});
            a = a + 64'(c) * 64'd32;
            n = n - c;
        end
    endfunction

    always @(negedge clk) begin
        bit   accept;
        req_t r;
        cyc++;
        if (!rstn) begin
            chk("rst_cmd_rdy", cmd_rdy, 0);
            if (rst_prev) begin
                chk("rst_vld", vld, 0);
                chk("rst_busy", busy, 0);
                chk("rst_credit", credit, DEPTH);
                chk("rst_pd", pd, 0);
            end
        end else if (mdl_on) begin
            chk("credit", credit, credit_m);
            chk("busy", busy, busy_m);
            chk("cmd_rdy", cmd_rdy, !busy_m);
            if (vld) begin
                if (expq.size() == 0) chk("vld_without_req", vld, 0);
                else begin
                    chk("pd", pd, mk_pd(expq[0].n, expq[0].addr));
                    chk("vld_credit", int'(credit) >= int'(expq[0].n), 1);
                end
            end
            if (prev_hold) begin
                chk("hold_vld", vld, 1);
                chk("hold_pd", pd, prev_pd);
            end
        end
        // advance the model to the state after the coming edge
        if (!rstn) begin
            expq.delete();
            credit_m  = DEPTH;
            busy_m    = 0;
            mdl_on    = 1;
            prev_hold = 0;
        end else if (mdl_on) begin
            accept = cmd_vld && !busy_m;
            if (vld && rdy && expq.size() > 0) begin
                r = expq.pop_front();
                credit_m -= int'(r.n);
                hs_cyc.push_back(cyc);
                hs_pd.push_back(pd);
                if (expq.size() == 0) busy_m = 0;
            end
            if (pop) credit_m = (credit_m + 1 > DEPTH) ? DEPTH : credit_m + 1;
            if (accept) begin
                split(cmd_addr, int'(cmd_size) + 1);
                busy_m  = 1;
                acc_cyc = cyc;
            end
            prev_hold = vld && !rdy;
            prev_pd   = pd;
        end
        rst_prev = !rstn;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; cmd_vld = 1'b0; pop = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        hs_pd.delete(); hs_cyc.delete();
    endtask

    task automatic send(input logic [63:0] a, input logic [14:0] s);
        bit got = 0;
        cmd_addr = a; cmd_size = s; cmd_vld = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (cmd_rdy) begin got = 1; break; end
        end
        if (!got) chk("cmd_accept_timeout", cmd_rdy, 1);
        tick();
        cmd_vld = 1'b0;
    endtask

    task automatic run_idle(input int unsigned rdy_pct, input int unsigned pop_pct);
        for (int i = 0; i < 20000; i++) begin
            if (!busy_m) break;
            rdy = ($urandom_range(99) < rdy_pct);
            pop = (credit_m < DEPTH) && ($urandom_range(99) < pop_pct);
            tick();
        end
        pop = 1'b0;
        if (busy_m) chk("idle_timeout", busy, 0);
    endtask

    task automatic wait_vld();
        for (int i = 0; i < 50; i++) begin
            if (vld) break;
            tick();
        end
        if (!vld) chk("vld_timeout", vld, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();

        // 4 KB split
        rdy = 1'b1;
        send(64'h0FC0, 15'd9);
        run_idle(100, 0);
        chk("t1_nreq", hs_pd.size(), 2);
        chk("t1_pd0", hs_pd[0], mk_pd(2, 64'h0FC0));
        chk("t1_pd1", hs_pd[1], mk_pd(8, 64'h1000));
        chk("t1_latency", hs_cyc[0] - acc_cyc, 2);
        chk("t1_rate", hs_cyc[1] - hs_cyc[0], 2);
        chk("t1_credit", credit, 54);

        // MAX_REQ_ATOMS split
        do_reset();
        rdy = 1'b1;
        send(64'h2000, 15'd19);
        run_idle(100, 0);
        chk("t2_nreq", hs_pd.size(), 3);
        chk("t2_pd0", hs_pd[0], mk_pd(8, 64'h2000));
        chk("t2_pd1", hs_pd[1], mk_pd(8, 64'h2100));
        chk("t2_pd2", hs_pd[2], mk_pd(4, 64'h2200));
        chk("t2_rate", hs_cyc[2] - hs_cyc[1], 2);
        chk("t2_credit", credit, 44);

        // credit throttle
        do_reset();
        rdy = 1'b1;
        send(64'h10000, 15'd127);
        for (int i = 0; i < 40; i++) tick();
        chk("t3_nreq", hs_pd.size(), 8);
        chk("t3_credit0", credit, 0);
        chk("t3_vld_off", vld, 0);
        chk("t3_busy", busy, 1);
        for (int i = 0; i < 8; i++) begin pop = 1'b1; tick(); end
        pop = 1'b0;
        chk("t3_credit8", credit, 8);
        chk("t3_vld_late", vld, 0);
        tick();
        chk("t3_vld_on", vld, 1);
        run_idle(100, 100);
        chk("t3_nreq_all", hs_pd.size(), 16);

        // backpressure hold
        do_reset();
        rdy = 1'b0;
        send(64'h3000, 15'd7);
        wait_vld();
        for (int k = 0; k < 5; k++) begin
            chk("t4_vld", vld, 1);
            chk("t4_pd", pd, mk_pd(8, 64'h3000));
            tick();
        end
        rdy = 1'b1;
        tick();
        chk("t4_nreq", hs_pd.size(), 1);
        chk("t4_busy", busy, 0);
`ifdef NVDLA_DMAIF_RDREQ_PERF_EN
        chk("t4_perf", perf, 5);
`endif

        // simultaneous handshake and pop
        do_reset();
        rdy = 1'b1;
        send(64'h4000, 15'd43);
        run_idle(100, 0);
        chk("t5_credit20", credit, 20);
        rdy = 1'b0;
        send(64'h5000, 15'd7);
        wait_vld();
        rdy = 1'b1; pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("t5_credit13", credit, 13);
        chk("t5_busy", busy, 0);

        // reset mid-operation
        rdy = 1'b0;
        send(64'h6000, 15'd15);
        wait_vld();
        rstn = 1'b0;
        tick();
        chk("t6_vld", vld, 0);
        chk("t6_busy", busy, 0);
        chk("t6_credit", credit, 64);
        chk("t6_cmd_rdy_rst", cmd_rdy, 0);
        rstn = 1'b1;
        tick();
        chk("t6_cmd_rdy", cmd_rdy, 1);

        // single atom, unaligned address, address wrap
        hs_pd.delete(); hs_cyc.delete();
        rdy = 1'b1;
        send(64'h7033, 15'd0);
        run_idle(100, 0);
        chk("t7_nreq", hs_pd.size(), 1);
        chk("t7_pd", hs_pd[0], mk_pd(1, 64'h7020));
        hs_pd.delete(); hs_cyc.delete();
        send(64'hFFFF_FFFF_FFFF_FFC0, 15'd3);
        run_idle(100, 0);
        chk("t8_nreq", hs_pd.size(), 2);
        chk("t8_pd0", hs_pd[0], mk_pd(2, 64'hFFFF_FFFF_FFFF_FFC0));
        chk("t8_pd1", hs_pd[1], mk_pd(2, 64'h0));

        // randomized commands with random backpressure and credit returns
        do_reset();
        for (int c = 0; c < 40; c++) begin
            logic [63:0] a;
            logic [14:0] s;
            a = {$urandom, $urandom};
            if ($urandom_range(1)) a[11:0] = 12'hF00 | 12'($urandom_range(255));
            s = ($urandom_range(9) == 0) ? 15'($urandom_range(300)) : 15'($urandom_range(40));
            send(a, s);
            run_idle(70, 50);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
